// File: rtl/l2_types.sv
// Shared types for the L2 port arbiter: FSM states, requester identity and
// default address/line widths.
package l2_types;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;

    typedef logic [ADDR_W-1:0] l2_addr_t;
    typedef logic [LINE_W-1:0] l2_line_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

endpackage

// File: rtl/l2_rr_pick.sv
// Two-way round-robin picker.
// Ports:
//   req_i, req_d  - pending requests from the I-side and D-side
//   last_grant    - side that won the previous arbitration
//   grant_valid   - at least one request is pending
//   winner        - side to grant; on a tie, the side that did not win last
module l2_rr_pick
    import l2_types::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  requester_t last_grant,
    output logic       grant_valid,
    output requester_t winner
);

    always_comb begin
        grant_valid = req_i | req_d;
        winner      = REQ_I;
        if (req_i && req_d) begin
            winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            winner = REQ_D;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Shares one L2 cache port between the I-side and D-side L1 miss paths.
// The winning request is registered onto the l2_* outputs and held until
// l2_resp; the response and read data are steered back to the owner.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   i_read/i_address      - I-side line read request
//   i_rdata/i_resp        - I-side read data and one-cycle completion
//   d_read/d_write        - D-side line read / writeback request
//   d_address/d_wdata     - D-side address and writeback data
//   d_rdata/d_resp        - D-side read data and one-cycle completion
//   l2_read/l2_write      - registered request to the L2 controller
//   l2_address/l2_wdata   - registered address and write data
//   l2_rdata/l2_resp      - L2 read data and one-cycle completion
module l2_arbiter
    import l2_types::*;
#(
    parameter int unsigned addr_width = ADDR_W,
    parameter int unsigned line_width = LINE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [addr_width-1:0] i_address,
    output logic [line_width-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [addr_width-1:0] d_address,
    input  logic [line_width-1:0] d_wdata,
    output logic [line_width-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [addr_width-1:0] l2_address,
    output logic [line_width-1:0] l2_wdata,
    input  logic [line_width-1:0] l2_rdata,
    input  logic                  l2_resp
);

    arb_state_t            state_q,      state_d;
    requester_t            last_grant_q, last_grant_d;
    logic                  read_q,       read_d;
    logic                  write_q,      write_d;
    logic [addr_width-1:0] address_q,    address_d;
    logic [line_width-1:0] wdata_q,      wdata_d;

    logic       grant_valid;
    requester_t winner;

    l2_rr_pick u_pick (
        .req_i       (i_read),
        .req_d       (d_read | d_write),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    // State and L2 request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_D;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state: grant from IDLE, hold while busy, release on l2_resp
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    last_grant_d = winner;
                    if (winner == REQ_I) begin
                        state_d   = BUSY_I;
                        read_d    = 1'b1;
                        write_d   = 1'b0;
                        address_d = i_address;
                        wdata_d   = '0;
                    end else begin
                        // Writeback wins over a simultaneous D-side read
                        state_d   = BUSY_D;
                        read_d    = ~d_write;
                        write_d   = d_write;
                        address_d = d_address;
                        wdata_d   = d_wdata;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (l2_resp) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    assign l2_read    = read_q;
    assign l2_write   = write_q;
    assign l2_address = address_q;
    assign l2_wdata   = wdata_q;

    // Completion goes only to the current owner; read data is broadcast
    assign i_resp  = l2_resp && (state_q == BUSY_I);
    assign d_resp  = l2_resp && (state_q == BUSY_D);
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: a transaction-level model predicts the
// order of L2 transactions and responses; a monitor checks them as they
// appear on the DUT ports.
module tb_l2_arbiter;
    import l2_types::*;

    typedef struct packed {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } txn_t;

    typedef struct packed {
        logic         side_d;
        logic [255:0] rdata;
    } resp_t;

    logic         clk, rst;
    logic         i_read, d_read, d_write;
    logic [31:0]  i_address, d_address, l2_address;
    logic [255:0] i_rdata, d_rdata, d_wdata, l2_wdata, l2_rdata;
    logic         i_resp, d_resp, l2_read, l2_write, l2_resp;

    int checks = 0;
    int errors = 0;

    txn_t  exp_txn_q[$];
    resp_t exp_resp_q[$];

    requester_t   model_last;
    bit           auto_resp;
    int           man_req_cnt;
    logic [255:0] man_rdata;

    l2_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_address  (i_address),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_rdata   (l2_rdata),
        .l2_resp    (l2_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] line_of(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_C3C3}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // L2 model: random-latency responder, or one-shot pulses on request
    initial begin
        int cnt;
        int seen;
        cnt = -1;
        seen = 0;
        l2_resp = 1'b0;
        l2_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            l2_resp = 1'b0;
            if (man_req_cnt != seen) begin
                seen = man_req_cnt;
                l2_resp = 1'b1;
                l2_rdata = man_rdata;
            end else if (auto_resp && !rst && (l2_read || l2_write)) begin
                if (cnt < 0) cnt = int'($urandom_range(0, 3));
                if (cnt == 0) begin
                    l2_resp = 1'b1;
                    l2_rdata = line_of(l2_address);
                    cnt = -1;
                end else begin
                    cnt--;
                end
            end else begin
                cnt = -1;
            end
        end
    end

    // Monitor: checks each new L2 transaction, its stability, and every response
    initial begin
        bit    prev_busy;
        bit    busy;
        bit    same;
        txn_t  cur;
        resp_t r;
        prev_busy = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            busy = l2_read || l2_write;
            if (busy && !prev_busy) begin
                if (exp_txn_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_l2_txn: got addr %0h expected none", l2_address);
                end else begin
                    cur = exp_txn_q.pop_front();
                    chk_bit("l2_read", l2_read, cur.rd);
                    chk_bit("l2_write", l2_write, cur.wr);
                    chk("l2_address", 256'(l2_address), 256'(cur.addr));
                    chk("l2_wdata", l2_wdata, cur.wdata);
                end
            end else if (busy) begin
                same = (l2_read === cur.rd) && (l2_write === cur.wr) &&
                       (l2_address === cur.addr) && (l2_wdata === cur.wdata);
                chk_bit("l2_hold", same, 1'b1);
            end
            prev_busy = busy;
            if (i_resp || d_resp) begin
                chk_bit("resp_onehot", i_resp && d_resp, 1'b0);
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
                end else begin
                    r = exp_resp_q.pop_front();
                    chk_bit("resp_side_d", d_resp, r.side_d);
                    chk("resp_rdata", r.side_d ? d_rdata : i_rdata, r.rdata);
                end
            end
        end
    end

    // Holds requests until each requested side sees its resp, then drops them
    task automatic wait_resp(input bit wi, input bit wd);
        int cyc;
        cyc = 0;
        while ((wi || wd) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (i_resp) wi = 1'b0;
            if (d_resp) wd = 1'b0;
            @(posedge clk);
            #1;
            if (!wi) i_read = 1'b0;
            if (!wd) begin
                d_read = 1'b0;
                d_write = 1'b0;
            end
        end
        chk_bit("resp_timeout", wi || wd, 1'b0);
    endtask

    // One arbitration round with the expected outcome derived from the rules
    task automatic do_round(input bit ri, input bit rd, input bit dr, input bit dw,
                            input logic [31:0] ai, input logic [31:0] ad,
                            input logic [255:0] wd);
        txn_t  ti, td;
        resp_t pi, pd;
        ti = '{rd: 1'b1, wr: 1'b0, addr: ai, wdata: '0};
        td = '{rd: !dw, wr: dw, addr: ad, wdata: wd};
        pi = '{side_d: 1'b0, rdata: line_of(ai)};
        pd = '{side_d: 1'b1, rdata: line_of(ad)};
        if (ri && rd) begin
            if (model_last == REQ_I) begin
                exp_txn_q.push_back(td); exp_resp_q.push_back(pd);
                exp_txn_q.push_back(ti); exp_resp_q.push_back(pi);
                model_last = REQ_I;
            end else begin
                exp_txn_q.push_back(ti); exp_resp_q.push_back(pi);
                exp_txn_q.push_back(td); exp_resp_q.push_back(pd);
                model_last = REQ_D;
            end
        end else if (ri) begin
            exp_txn_q.push_back(ti); exp_resp_q.push_back(pi);
            model_last = REQ_I;
        end else if (rd) begin
            exp_txn_q.push_back(td); exp_resp_q.push_back(pd);
            model_last = REQ_D;
        end
        @(posedge clk);
        #1;
        i_read = ri;
        i_address = ai;
        d_read = rd && dr;
        d_write = rd && dw;
        d_address = ad;
        d_wdata = wd;
        wait_resp(ri, rd);
    endtask

    initial begin
        logic [255:0] w;
        logic [31:0]  sel;
        int           op;
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;
        auto_resp = 1'b0;
        man_req_cnt = 0;
        man_rdata = '0;
        model_last = REQ_D;

        // Reset state
        repeat (2) @(negedge clk);
        chk_bit("rst_l2_read", l2_read, 1'b0);
        chk_bit("rst_l2_write", l2_write, 1'b0);
        chk("rst_l2_address", 256'(l2_address), '0);
        chk("rst_l2_wdata", l2_wdata, '0);
        chk_bit("rst_i_resp", i_resp, 1'b0);
        chk_bit("rst_d_resp", d_resp, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_bit("idle_no_req", l2_read || l2_write, 1'b0);
        end

        // Lone I read, one-cycle latency, directed read data
        @(posedge clk); #1;
        i_read = 1'b1;
        i_address = 32'h0000_1000;
        exp_txn_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1000, wdata: '0});
        exp_resp_q.push_back('{side_d: 1'b0, rdata: {32{8'hA5}}});
        model_last = REQ_I;
        @(negedge clk);
        chk_bit("lat_cycle_n", l2_read, 1'b0);
        @(negedge clk);
        chk_bit("lat_cycle_n1", l2_read, 1'b1);
        man_rdata = {32{8'hA5}};
        man_req_cnt++;
        wait_resp(1'b1, 1'b0);

        // Tie straight out of reset: I first, then D
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        model_last = REQ_D;
        auto_resp = 1'b1;
        do_round(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1100, 32'h0000_2200, '0);

        // D writeback held stable through 5 wait cycles while inputs change
        auto_resp = 1'b0;
        w = {8{32'h1234_5678}};
        @(posedge clk); #1;
        d_write = 1'b1;
        d_address = 32'h0000_2000;
        d_wdata = w;
        exp_txn_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h0000_2000, wdata: w});
        exp_resp_q.push_back('{side_d: 1'b1, rdata: {8{32'hDEAD_BEEF}}});
        model_last = REQ_D;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            d_wdata = {8{$urandom}};
            d_address = $urandom;
        end
        chk("wb_wdata_held", l2_wdata, w);
        man_rdata = {8{32'hDEAD_BEEF}};
        man_req_cnt++;
        wait_resp(1'b0, 1'b1);

        // Read+write together -> write; then a stray l2_resp while idle
        auto_resp = 1'b1;
        do_round(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_3000, {8{32'h0BAD_F00D}});
        @(negedge clk);
        man_rdata = {32{8'h77}};
        man_req_cnt++;
        @(negedge clk);
        chk_bit("spurious_i_resp", i_resp, 1'b0);
        chk_bit("spurious_d_resp", d_resp, 1'b0);
        chk_bit("spurious_idle", l2_read || l2_write, 1'b0);

        // Reset in BUSY_D before l2_resp abandons the transaction
        auto_resp = 1'b0;
        w = {8{32'hCAFE_0001}};
        @(posedge clk); #1;
        d_write = 1'b1;
        d_address = 32'h0000_4000;
        d_wdata = w;
        exp_txn_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h0000_4000, wdata: w});
        repeat (2) @(negedge clk);
        chk_bit("pre_rst_write", l2_write, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_bit("mid_rst_write", l2_write, 1'b0);
        chk_bit("mid_rst_d_resp", d_resp, 1'b0);
        chk("mid_rst_addr", 256'(l2_address), '0);
        d_write = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        model_last = REQ_D;
        auto_resp = 1'b1;
        do_round(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_4000, w);

        // Randomized rounds
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(1, 3);
            op = int'($urandom_range(0, 2));
            for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom;
            do_round(sel[0], sel[1], op != 1, op != 0,
                     $urandom & 32'hFFFF_FFE0, $urandom & 32'hFFFF_FFE0, w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        chk("txn_queue_empty", 256'(exp_txn_q.size()), '0);
        chk("resp_queue_empty", 256'(exp_resp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
